// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter
module ps2_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic [1:0] tx_err
);

    localparam logic [19:0] RTS_LOAD = 20'(RTS_CYCLES - 1);
    localparam logic [19:0] TO_LOAD  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  filter_reg, filter_next;
    logic        f_ps2c_reg, f_ps2c_next;
    logic        fall_edge;
    logic [19:0] cnt_reg, cnt_next;
    logic [3:0]  n_reg, n_next;
    logic [8:0]  b_reg, b_next;
    logic        c_low_reg, c_low_next;
    logic        d_low_reg, d_low_next;
    logic        done_reg, done_next;
    logic [1:0]  err_reg, err_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            filter_reg <= '0;
            f_ps2c_reg <= 1'b0;
            cnt_reg    <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
            c_low_reg  <= 1'b0;
            d_low_reg  <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 2'b00;
        end else begin
            state_reg  <= state_next;
            filter_reg <= filter_next;
            f_ps2c_reg <= f_ps2c_next;
            cnt_reg    <= cnt_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
            c_low_reg  <= c_low_next;
            d_low_reg  <= d_low_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    // Glitch filter: the filtered clock only moves after eight agreeing samples.
    always_comb begin
        filter_next = {ps2c, filter_reg[7:1]};
        f_ps2c_next = f_ps2c_reg;
        if (filter_next == 8'hFF)
            f_ps2c_next = 1'b1;
        else if (filter_next == 8'h00)
            f_ps2c_next = 1'b0;
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wr_ps2) begin
                    b_next     = {~^din, din};
                    err_next   = 2'b00;
                    cnt_next   = RTS_LOAD;
                    state_next = RTS;
                end
            end
            RTS: begin
                if (cnt_reg == 20'd0) begin
                    cnt_next   = TO_LOAD;
                    state_next = START;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                end
            end
            START, DATA, STOP, ACK: begin
                // A device edge coinciding with counter expiry takes priority.
                if (fall_edge) begin
                    cnt_next = TO_LOAD;
                    case (state_reg)
                        START: begin
                            n_next     = 4'd8;
                            state_next = DATA;
                        end
                        DATA: begin
                            b_next = {1'b0, b_reg[8:1]};
                            if (n_reg == 4'd0)
                                state_next = STOP;
                            else
                                n_next = n_reg - 4'd1;
                        end
                        STOP: state_next = ACK;
                        default: begin
                            err_next   = ps2d ? 2'b01 : 2'b00;
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    endcase
                end else if (cnt_reg == 20'd0) begin
                    err_next   = 2'b10;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        c_low_next = (state_next == RTS);
        d_low_next = (state_next == START) || ((state_next == DATA) && !b_next[0]);
    end

    assign ps2c         = c_low_reg ? 1'b0 : 1'bz;
    assign ps2d         = d_low_reg ? 1'b0 : 1'bz;
    assign tx_idle      = (state_reg == IDLE);
    assign tx_done_tick = done_reg;
    assign tx_err       = err_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - directed bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_idle, tx_done_tick;
    logic [1:0] tx_err;
    wire        ps2c, ps2d;
    logic       dev_c = 1'b0;
    logic       dev_d = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_idle = 1'b0;

    logic        rx_c_q = 1'b1;
    logic [10:0] rx_sh = '0;
    int          rx_n = 0;
    int          rx_cnt = 0;
    logic [7:0]  rx_byte = '0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_tx #(.RTS_CYCLES(16), .TIMEOUT_CYCLES(400)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_idle = tx_idle;
        end
    end

    // Receiver stand-in with rx_en tied to tx_idle.
    always @(posedge clk) begin
        rx_c_q <= ps2c;
        if (!tx_idle) begin
            rx_n <= 0;
        end else if (rx_c_q && !ps2c) begin
            rx_sh <= {ps2d, rx_sh[10:1]};
            if (rx_n == 10) begin
                rx_n    <= 0;
                rx_cnt  <= rx_cnt + 1;
                rx_byte <= rx_sh[9:2];
            end else begin
                rx_n <= rx_n + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_start(input logic [7:0] v);
        @(negedge clk);
        din    = v;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    // Device side of a host-to-device frame: bits[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_frame(input int n_edges, input bit ack_low, output logic [10:0] bits,
                             output int rts_len, output int last_fall);
        int guard;
        bits = '0; rts_len = 0; last_fall = 0; guard = 0;
        while (ps2c !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        while (ps2c === 1'b0 && rts_len < 1000) begin
            rts_len++;
            @(negedge clk);
        end
        bits[0] = ps2d;
        repeat (15) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_c     = 1'b1;
            last_fall = cyc;
            repeat (20) @(negedge clk);
            if (k <= 10) bits[k] = ps2d;
            if (k == 12) dev_d = 1'b0;
            dev_c = 1'b0;
            repeat (20) @(negedge clk);
            if (k == 11 && ack_low) dev_d = 1'b1;
        end
    endtask

    task automatic dev_send(input logic [7:0] v);
        logic [10:0] f;
        f = {1'b1, ~^v, v, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_d = ~f[i];
            repeat (10) @(negedge clk);
            dev_c = 1'b1;
            repeat (20) @(negedge clk);
            dev_c = 1'b0;
            repeat (10) @(negedge clk);
        end
        dev_d = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx_idle !== 1'b1 || tx_done_tick !== 1'b0 || tx_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: idle=%b done=%b err=%b expected 1 0 00", tx_idle, tx_done_tick, tx_err);
        end
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1) begin
            errors++;
            $display("FAIL reset_lines: ps2c=%b ps2d=%b expected 1 1", ps2c, ps2d);
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_idle !== 1'b1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL post_reset_idle: idle=%b done_cnt=%0d expected 1 0", tx_idle, done_cnt);
        end
    endtask

    task automatic test_byte_f4();
        logic [10:0] bits;
        int rts_len, last_fall, d0;
        d0 = done_cnt;
        send_start(8'hF4);
        checks++;
        if (ps2c !== 1'b0 || tx_idle !== 1'b0) begin
            errors++;
            $display("FAIL f4_rts_start: ps2c=%b idle=%b expected 0 0", ps2c, tx_idle);
        end
        dev_frame(12, 1'b1, bits, rts_len, last_fall);
        checks++;
        if (rts_len !== 16) begin
            errors++;
            $display("FAIL f4_rts_len: got %0d expected 16", rts_len);
        end
        checks++;
        if (bits !== 11'h5E8) begin
            errors++;
            $display("FAIL f4_frame: got %h expected 5e8", bits);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || tx_err !== 2'b00 || done_idle !== 1'b1) begin
            errors++;
            $display("FAIL f4_done: ticks=%0d err=%b idle_at_tick=%b expected 1 00 1", done_cnt - d0, tx_err, done_idle);
        end
        checks++;
        if (done_cyc - last_fall < 8 || done_cyc - last_fall > 9) begin
            errors++;
            $display("FAIL f4_done_latency: got %0d expected 8..9", done_cyc - last_fall);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  vals [2];
        logic [10:0] exp  [2];
        logic [10:0] bits;
        int rts_len, last_fall, d0;
        vals[0] = 8'h00; exp[0] = 11'h600;
        vals[1] = 8'hFF; exp[1] = 11'h7FE;
        for (int i = 0; i < 2; i++) begin
            d0 = done_cnt;
            send_start(vals[i]);
            dev_frame(12, 1'b1, bits, rts_len, last_fall);
            repeat (5) @(negedge clk);
            checks++;
            if (bits[9] !== 1'b1 || bits !== exp[i]) begin
                errors++;
                $display("FAIL parity_frame_%0d: got %h expected %h", i, bits, exp[i]);
            end
            checks++;
            if (done_cnt - d0 !== 1 || tx_err !== 2'b00) begin
                errors++;
                $display("FAIL parity_done_%0d: ticks=%0d err=%b expected 1 00", i, done_cnt - d0, tx_err);
            end
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        int rts_len, last_fall, d0;
        d0 = done_cnt;
        send_start(8'hED);
        dev_frame(12, 1'b0, bits, rts_len, last_fall);
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || tx_err !== 2'b01) begin
            errors++;
            $display("FAIL nack: ticks=%0d err=%b expected 1 01", done_cnt - d0, tx_err);
        end
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1 || tx_idle !== 1'b1) begin
            errors++;
            $display("FAIL nack_lines: ps2c=%b ps2d=%b idle=%b expected 1 1 1", ps2c, ps2d, tx_idle);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        int rts_len, last_fall, d0, guard;
        d0 = done_cnt;
        guard = 0;
        send_start(8'h00);
        dev_frame(4, 1'b0, bits, rts_len, last_fall);
        while (done_cnt == d0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || tx_err !== 2'b10) begin
            errors++;
            $display("FAIL timeout_result: ticks=%0d err=%b expected 1 10", done_cnt - d0, tx_err);
        end
        checks++;
        if (done_cyc - last_fall < 408 || done_cyc - last_fall > 409) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 408..409", done_cyc - last_fall);
        end
        checks++;
        if (tx_idle !== 1'b1 || ps2d !== 1'b1 || ps2c !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: idle=%b ps2c=%b ps2d=%b expected 1 1 1", tx_idle, ps2c, ps2d);
        end
    endtask

    task automatic test_ignored_wr();
        logic [10:0] bits;
        int rts_len, last_fall, d0;
        d0 = done_cnt;
        send_start(8'h3C);
        fork
            dev_frame(12, 1'b1, bits, rts_len, last_fall);
            begin
                repeat (200) @(negedge clk);
                din    = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        checks++;
        if (bits !== 11'h678) begin
            errors++;
            $display("FAIL ignored_wr_frame: got %h expected 678", bits);
        end
        checks++;
        if (done_cnt - d0 !== 1 || tx_err !== 2'b00) begin
            errors++;
            $display("FAIL ignored_wr_done: ticks=%0d err=%b expected 1 00", done_cnt - d0, tx_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        int rts_len, last_fall, d0;
        send_start(8'h00);
        dev_frame(3, 1'b0, bits, rts_len, last_fall);
        checks++;
        if (ps2d !== 1'b0 || tx_idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_data_drive: ps2d=%b idle=%b expected 0 0", ps2d, tx_idle);
        end
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1 || tx_idle !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_release: ps2c=%b ps2d=%b idle=%b expected 1 1 1", ps2c, ps2d, tx_idle);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (450) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || tx_idle !== 1'b1 || tx_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_tick: ticks=%0d idle=%b err=%b expected 0 1 00", done_cnt - d0, tx_idle, tx_err);
        end
    endtask

    task automatic test_rx_gating();
        logic [10:0] bits;
        int rts_len, last_fall, r0, d0;
        r0 = rx_cnt;
        send_start(8'hF4);
        dev_frame(12, 1'b1, bits, rts_len, last_fall);
        repeat (5) @(negedge clk);
        checks++;
        if (rx_cnt !== r0) begin
            errors++;
            $display("FAIL rx_gated: got %0d bytes expected 0", rx_cnt - r0);
        end
        d0 = done_cnt;
        dev_send(8'hFA);
        repeat (20) @(negedge clk);
        checks++;
        if (rx_cnt - r0 !== 1 || rx_byte !== 8'hFA) begin
            errors++;
            $display("FAIL rx_reply: count=%0d byte=%h expected 1 fa", rx_cnt - r0, rx_byte);
        end
        checks++;
        if (done_cnt !== d0 || tx_idle !== 1'b1) begin
            errors++;
            $display("FAIL rx_idle_quiet: ticks=%0d idle=%b expected 0 1", done_cnt - d0, tx_idle);
        end
    endtask

    initial begin
        test_reset();
        test_byte_f4();
        test_parity();
        test_nack();
        test_timeout();
        test_ignored_wr();
        test_reset_mid();
        test_rx_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter. It sends one command byte to a PS/2 device (keyboard or mouse) using the standard inhibit/request-to-send sequence, odd parity, stop bit and device acknowledge. It drives the shared open-collector `ps2c`/`ps2d` lines and sits beside the PS/2 receiver. `tx_idle` feeds the receiver's `rx_en`, so the receiver only listens while no transmission is in progress.

## Interface

- `RTS_CYCLES`, default 5000: clock cycles `ps2c` is held low for request-to-send. 100 µs at 50 MHz.
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles allowed between device clock falling edges before the transfer aborts. 15 ms at 50 MHz.
- Both parameters must be ≥ 2 and < 2^20. One 20-bit down-counter serves both.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_ps2`  in  1  start request; sampled only in `idle`.
- `din`  in  8  byte to send; captured on an accepted `wr_ps2`.
- `ps2c`  inout  1  PS/2 clock. Driven 0 or high-Z only.
- `ps2d`  inout  1  PS/2 data. Driven 0 or high-Z only.
- `tx_idle`  out  1  high only in state `idle`.
- `tx_done_tick`  out  1  one-cycle pulse at the end of every transfer, whether it succeeds or fails.
- `tx_err`  out  2  transfer result: 00 = ok, 01 = NACK, 10 = timeout. Updated on `tx_done_tick`, held until the next accepted request, cleared to 00 on acceptance.

## Operation

**Clock filter.**
- 8-bit shift filter on `ps2c`: filtered clock goes to 1 after eight consecutive 1 samples, to 0 after eight consecutive 0 samples, otherwise holds.
- `fall_edge` = filtered register & ~filtered next value.

**Transmit frame.**
- Frame register `b = {~^din, din}`: 9 bits, odd parity in the MSB, sent LSB first.
- Bit counter `n` runs 8 down to 0.

**States.**
- `idle`
  - Both lines released.
  - `wr_ps2` loads `b`, clears `tx_err`, sets counter to `RTS_CYCLES-1`, goes to `rts`.
  - This happens even if a `fall_edge` occurs in the same cycle.
- `rts`
  - `ps2c` driven 0, `ps2d` released.
  - Counter decrements each cycle.
  - At 0: go to `start`, counter := `TIMEOUT_CYCLES-1`.
- `start`
  - `ps2c` released, `ps2d` driven 0 (start bit).
  - On `fall_edge`: go to `data`, `n := 8`, reload timeout.
- `data`
  - `ps2d` driven 0 when `b[0]`=0, released when `b[0]`=1.
  - On `fall_edge`: shift `b` right, reload timeout.
  - If `n`=0 go to `stop`, else decrement `n`.
- `stop`
  - `ps2d` released (stop bit = 1).
  - On `fall_edge`: go to `ack`, reload timeout.
- `ack`
  - Lines released.
  - On `fall_edge`: sample raw `ps2d`. 0 → `tx_err`=00; 1 → `tx_err`=01.
  - Then pulse `tx_done_tick` and return to `idle`.
- Timeout:
  - Applies in `start`, `data`, `stop` and `ack`.
  - If the counter reaches 0 with no `fall_edge`: `tx_err`=10, pulse `tx_done_tick`, release both lines, return to `idle`.
  - `fall_edge` in the same cycle as counter 0 wins: the edge is processed, no timeout.

**Other rules.**
- `wr_ps2` outside `idle` is ignored. `din` is not re-sampled.
- Reset mid-transfer releases both lines immediately (asynchronous). State returns to `idle`; no `tx_done_tick`.
- Tri-state enables and drive values are registered outputs of the FSM, so pins are glitch-free.

## Timing

**Reset values.**
- state `idle`, `tx_idle`=1, `tx_done_tick`=0, `tx_err`=00.
- Both lines released; filter register 0; filtered clock 0; counter 0; `n`=0; `b`=0.

**Cycle-level behaviour.**
- `ps2c` is first driven low on the cycle after `wr_ps2` is sampled.
- `ps2c` stays low for exactly `RTS_CYCLES` cycles.
- `ps2d` goes low on the same edge that releases `ps2c`.
- `fall_edge` lags the pin by 8–9 `clk` cycles because of the filter. Each new data bit is driven on the cycle after its `fall_edge`.
- `tx_done_tick` is asserted one cycle after the 11th device `fall_edge` after `start` (the ack edge). `tx_idle` returns high on that same cycle.
- Back-to-back transfers: `wr_ps2` may be asserted in the first `idle` cycle after `tx_done_tick`.

## Test plan

Bench uses `RTS_CYCLES`=16, `TIMEOUT_CYCLES`=400, and a PS/2 device model with a 40-`clk` clock period.

1. **Byte 0xF4.** `wr_ps2` with `din`=0xF4, device acks → `ps2c` low 16 cycles; device samples 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; `tx_done_tick` once, `tx_err`=00.
2. **Parity.** Send 0x00 then 0xFF → parity bit 1, then 1; both transfers give `tx_err`=00.
3. **NACK.** Device leaves `ps2d` high at the ack edge → `tx_err`=01, `tx_done_tick` once, lines released.
4. **Timeout.** Device stops clocking after bit 3 → after 400 cycles `tx_err`=10, `tx_done_tick` pulses, state `idle`, `ps2d` released.
5. **Ignored request and reset.** `wr_ps2` pulsed during `data` → frame unaffected. Then `reset`=0 held one cycle mid-`data` → both lines high-Z immediately, `tx_idle`=1, no `tx_done_tick`.
6. **Receiver gating.** `tx_idle` wired to receiver `rx_en` → receiver reports no byte during the transmit; a device reply of 0xFA after completion is received correctly.
